// File: rtl/rename_queue_if.sv
// ============================================================================
//  Module   : rename_queue_if (with rename_queue_pkg)
//  Brief    : Micro-op type and decode/rename handshake bundle for rename_queue
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef RENAME_WIDTH
`define RENAME_WIDTH 2
`endif

package rename_queue_pkg;
   typedef struct packed {
      logic [7:0] opcode;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [8:0] imm;
   } micro_op_t;
endpackage

interface rename_queue_if #(
   parameter int WIDTH = `RENAME_WIDTH,
   parameter int DEPTH = 8
);
   import rename_queue_pkg::*;

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             recover;
   logic [WIDTH-1:0] in_valid;
   micro_op_t        uop_in [WIDTH];
   logic             in_ready;
   logic             out_ready;
   logic [WIDTH-1:0] out_valid;
   micro_op_t        uop_out [WIDTH];
   logic [CNT_W-1:0] count;

   modport master (
      output recover, in_valid, uop_in, out_ready,
      input  in_ready, out_valid, uop_out, count
   );

   modport slave (
      input  recover, in_valid, uop_in, out_ready,
      output in_ready, out_valid, uop_out, count
   );
endinterface

`default_nettype wire

// File: rtl/rename_queue.sv
// ============================================================================
//  Module   : rename_queue
//  Brief    : Multi-lane circular uop queue between decode and rename
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef RENAME_WIDTH
`define RENAME_WIDTH 2
`endif

module rename_queue #(
   parameter int WIDTH = `RENAME_WIDTH,
   parameter int DEPTH = 8
) (
   input  logic          clock,
   input  logic          reset,
   rename_queue_if.slave q
);
   import rename_queue_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   micro_op_t        r_mem [DEPTH];

   logic             w_in_ready;
   logic             w_push;
   logic             w_pop;
   logic [CNT_W-1:0] w_npush;
   logic [CNT_W-1:0] w_add;
   logic [CNT_W-1:0] w_npop;
   logic [PTR_W-1:0] w_slot [WIDTH];
   logic [WIDTH-1:0] w_out_valid;

   // Admission looks only at registered occupancy, never at a same-cycle pop.
   always_comb begin
      w_in_ready = (r_count <= CNT_W'(DEPTH - WIDTH));
      w_push     = w_in_ready && (|q.in_valid) && !q.recover;
      w_npush    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_slot[i] = r_tail + PTR_W'(w_npush);
         if (q.in_valid[i]) begin
            w_npush = w_npush + CNT_W'(1);
         end
      end
      w_add  = w_push ? w_npush : '0;
      w_pop  = q.out_ready && (r_count != '0);
      w_npop = '0;
      if (w_pop) begin
         w_npop = (r_count < CNT_W'(WIDTH)) ? r_count : CNT_W'(WIDTH);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (q.recover) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PTR_W'(w_npush);
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(w_npop);
         end
         r_count <= r_count + w_add - w_npop;
      end
   end

   // Storage is intentionally unreset; valid lanes are compacted into slots from tail.
   always_ff @(posedge clock) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (w_push && q.in_valid[i]) begin
            r_mem[w_slot[i]] <= q.uop_in[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         w_out_valid[i] = (CNT_W'(i) < r_count);
         q.uop_out[i]   = w_out_valid[i] ? r_mem[r_head + PTR_W'(i)] : '0;
      end
   end

   assign q.out_valid = w_out_valid;
   assign q.in_ready  = w_in_ready;
   assign q.count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_rename_queue.sv
// ============================================================================
//  Module   : tb_rename_queue
//  Brief    : Directed self-checking bench for rename_queue (WIDTH=2, DEPTH=8)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rename_queue;
   import rename_queue_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [31:0] model_q [$];

   rename_queue_if #(.WIDTH(2), .DEPTH(8)) q ();

   rename_queue #(.WIDTH(2), .DEPTH(8)) dut (
      .clock (clk),
      .reset (rst_n),
      .q     (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic micro_op_t u(input logic [31:0] v);
      return micro_op_t'(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      q.recover   = 1'b0;
      q.in_valid  = 2'b00;
      q.out_ready = 1'b0;
      q.uop_in[0] = u(32'h0);
      q.uop_in[1] = u(32'h0);
   endtask

   task automatic push2(input logic [31:0] a, input logic [31:0] b);
      q.in_valid  = 2'b11;
      q.uop_in[0] = u(a);
      q.uop_in[1] = u(b);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      #12;
      checks++; if (q.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", q.count); end
      checks++; if (q.out_valid !== 2'b00) begin errors++; $display("FAIL reset_out_valid got %b exp 00", q.out_valid); end
      checks++; if (q.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", q.in_ready); end
      checks++; if (q.uop_out[0] !== u(32'h0)) begin errors++; $display("FAIL reset_uop0 got %h exp 0", q.uop_out[0]); end
      #10;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_push_pair();
      push2(32'h100, 32'h101);
      tick();
      idle();
      checks++; if (q.count !== 4'd2) begin errors++; $display("FAIL pair_count got %0d exp 2", q.count); end
      checks++; if (q.out_valid !== 2'b11) begin errors++; $display("FAIL pair_out_valid got %b exp 11", q.out_valid); end
      checks++; if (q.uop_out[0] !== u(32'h100)) begin errors++; $display("FAIL pair_uop0 got %h exp 100", q.uop_out[0]); end
      checks++; if (q.uop_out[1] !== u(32'h101)) begin errors++; $display("FAIL pair_uop1 got %h exp 101", q.uop_out[1]); end
   endtask

   task automatic test_fill();
      for (int g = 1; g < 4; g++) begin
         push2(32'h100 + 32'(2 * g), 32'h101 + 32'(2 * g));
         tick();
      end
      idle();
      checks++; if (q.count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", q.count); end
      checks++; if (q.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", q.in_ready); end
      push2(32'h1EE, 32'h1EF);
      tick();
      idle();
      checks++; if (q.count !== 4'd8) begin errors++; $display("FAIL full_blocked_count got %0d exp 8", q.count); end
      q.out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         checks++; if (q.uop_out[0] !== u(32'h100 + 32'(2 * j))) begin errors++; $display("FAIL full_drain_uop0[%0d] got %h exp %h", j, q.uop_out[0], 32'h100 + 32'(2 * j)); end
         checks++; if (q.uop_out[1] !== u(32'h101 + 32'(2 * j))) begin errors++; $display("FAIL full_drain_uop1[%0d] got %h exp %h", j, q.uop_out[1], 32'h101 + 32'(2 * j)); end
         tick();
      end
      idle();
      checks++; if (q.count !== 4'd0) begin errors++; $display("FAIL full_drain_count got %0d exp 0", q.count); end
   endtask

   task automatic test_partial_pop();
      for (int g = 0; g < 3; g++) begin
         push2(32'h200 + 32'(2 * g), 32'h201 + 32'(2 * g));
         tick();
      end
      idle();
      checks++; if (q.in_ready !== 1'b1) begin errors++; $display("FAIL six_in_ready got %b exp 1", q.in_ready); end
      q.in_valid  = 2'b01;
      q.uop_in[0] = u(32'h206);
      tick();
      idle();
      checks++; if (q.count !== 4'd7) begin errors++; $display("FAIL seven_count got %0d exp 7", q.count); end
      checks++; if (q.in_ready !== 1'b0) begin errors++; $display("FAIL seven_in_ready got %b exp 0", q.in_ready); end
      q.out_ready = 1'b1;
      tick();
      checks++; if (q.count !== 4'd5) begin errors++; $display("FAIL pop2_count got %0d exp 5", q.count); end
      checks++; if (q.in_ready !== 1'b1) begin errors++; $display("FAIL pop2_in_ready got %b exp 1", q.in_ready); end
      tick();
      tick();
      checks++; if (q.out_valid !== 2'b01) begin errors++; $display("FAIL tail1_out_valid got %b exp 01", q.out_valid); end
      checks++; if (q.uop_out[0] !== u(32'h206)) begin errors++; $display("FAIL tail1_uop0 got %h exp 206", q.uop_out[0]); end
      checks++; if (q.uop_out[1] !== u(32'h0)) begin errors++; $display("FAIL tail1_uop1 got %h exp 0", q.uop_out[1]); end
      tick();
      idle();
      checks++; if (q.count !== 4'd0) begin errors++; $display("FAIL minpop_count got %0d exp 0", q.count); end
   endtask

   task automatic test_lane1_only();
      q.in_valid  = 2'b10;
      q.uop_in[0] = u(32'h3FF);
      q.uop_in[1] = u(32'h300);
      tick();
      idle();
      checks++; if (q.out_valid !== 2'b01) begin errors++; $display("FAIL lane1_out_valid got %b exp 01", q.out_valid); end
      checks++; if (q.uop_out[0] !== u(32'h300)) begin errors++; $display("FAIL lane1_uop0 got %h exp 300", q.uop_out[0]); end
      checks++; if (q.count !== 4'd1) begin errors++; $display("FAIL lane1_count got %0d exp 1", q.count); end
      q.out_ready = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] nv;
      nv = 32'h400;
      model_q.delete();
      for (int g = 0; g < 2; g++) begin
         push2(nv, nv + 1);
         model_q.push_back(nv);
         model_q.push_back(nv + 1);
         nv = nv + 2;
         tick();
      end
      for (int c = 0; c < 20; c++) begin
         push2(nv, nv + 1);
         q.out_ready = 1'b1;
         checks++; if (q.count !== 4'd4) begin errors++; $display("FAIL b2b_count[%0d] got %0d exp 4", c, q.count); end
         checks++; if (q.uop_out[0] !== u(model_q[0])) begin errors++; $display("FAIL b2b_uop0[%0d] got %h exp %h", c, q.uop_out[0], model_q[0]); end
         checks++; if (q.uop_out[1] !== u(model_q[1])) begin errors++; $display("FAIL b2b_uop1[%0d] got %h exp %h", c, q.uop_out[1], model_q[1]); end
         tick();
         void'(model_q.pop_front());
         void'(model_q.pop_front());
         model_q.push_back(nv);
         model_q.push_back(nv + 1);
         nv = nv + 2;
      end
      idle();
      q.out_ready = 1'b1;
      for (int d = 0; d < 2; d++) begin
         checks++; if (q.uop_out[0] !== u(model_q[0])) begin errors++; $display("FAIL b2b_drain_uop0[%0d] got %h exp %h", d, q.uop_out[0], model_q[0]); end
         tick();
         void'(model_q.pop_front());
         void'(model_q.pop_front());
      end
      idle();
      checks++; if (q.count !== 4'd0) begin errors++; $display("FAIL b2b_final_count got %0d exp 0", q.count); end
   endtask

   task automatic test_recover();
      for (int g = 0; g < 3; g++) begin
         push2(32'h500 + 32'(2 * g), 32'h501 + 32'(2 * g));
         tick();
      end
      push2(32'h5A0, 32'h5A1);
      q.out_ready = 1'b1;
      q.recover   = 1'b1;
      checks++; if (q.out_valid !== 2'b11) begin errors++; $display("FAIL rec_pre_out_valid got %b exp 11", q.out_valid); end
      checks++; if (q.uop_out[0] !== u(32'h500)) begin errors++; $display("FAIL rec_pre_uop0 got %h exp 500", q.uop_out[0]); end
      tick();
      idle();
      checks++; if (q.count !== 4'd0) begin errors++; $display("FAIL rec_count got %0d exp 0", q.count); end
      checks++; if (q.out_valid !== 2'b00) begin errors++; $display("FAIL rec_out_valid got %b exp 00", q.out_valid); end
      checks++; if (q.in_ready !== 1'b1) begin errors++; $display("FAIL rec_in_ready got %b exp 1", q.in_ready); end
      push2(32'h510, 32'h511);
      tick();
      idle();
      checks++; if (q.uop_out[0] !== u(32'h510)) begin errors++; $display("FAIL rec_repush_uop0 got %h exp 510", q.uop_out[0]); end
      checks++; if (q.count !== 4'd2) begin errors++; $display("FAIL rec_repush_count got %0d exp 2", q.count); end
   endtask

   task automatic test_async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (q.count !== 4'd0) begin errors++; $display("FAIL areset_count got %0d exp 0", q.count); end
      checks++; if (q.out_valid !== 2'b00) begin errors++; $display("FAIL areset_out_valid got %b exp 00", q.out_valid); end
      checks++; if (q.uop_out[0] !== u(32'h0)) begin errors++; $display("FAIL areset_uop0 got %h exp 0", q.uop_out[0]); end
      #2;
      rst_n = 1'b1;
      push2(32'h600, 32'h601);
      tick();
      idle();
      checks++; if (q.count !== 4'd2) begin errors++; $display("FAIL post_reset_count got %0d exp 2", q.count); end
      checks++; if (q.uop_out[0] !== u(32'h600)) begin errors++; $display("FAIL post_reset_uop0 got %h exp 600", q.uop_out[0]); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_push_pair();
      test_fill();
      test_partial_pop();
      test_lane1_only();
      test_back_to_back();
      test_recover();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rename_queue.md
RENAME_QUEUE -- requirements
Module: rename_queue

Interface
REQ-001 SHALL have parameter WIDTH, default `RENAME_WIDTH, meaning the number of uop lanes on the input and output sides.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the number of entries; it must be a power of two and at least 2*WIDTH.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port recover, input, 1 bit: flush request on branch mispredict or recovery.
REQ-006 SHALL have port in_valid, input, WIDTH bits: per-lane valid for decoded uops.
REQ-007 SHALL have port uop_in, input, micro_op_t [WIDTH]: decoded uops.
REQ-008 SHALL have port in_ready, output, 1 bit: the queue accepts an input group this cycle.
REQ-009 SHALL have port out_ready, input, 1 bit: rename consumes the output group; it is driven as !pause && allocatable.
REQ-010 SHALL have port out_valid, output, WIDTH bits: per-lane valid toward rename, contiguous from lane 0.
REQ-011 SHALL have port uop_out, output, micro_op_t [WIDTH]: the oldest uops, in order.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-013 SHALL store uops in a circular buffer with head (oldest) and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-014 SHALL drive in_ready = (DEPTH - count >= WIDTH), computed from the registered count only, ignoring any same-cycle pop.
REQ-015 SHALL accept a push when in_ready && |in_valid, writing npush = popcount(in_valid) entries.
REQ-016 SHALL compact valid input lanes in ascending lane order into consecutive slots starting at tail.
- Example: in_valid=2'b10 writes uop_in[1] at tail.
REQ-017 SHALL ignore in_valid while in_ready=0; no entry is written and no state changes from the push side.
REQ-018 SHALL drive out_valid[i]=1 iff i < count, and uop_out[i] = entry[(head+i) mod DEPTH].
REQ-019 SHALL drive uop_out[i] to all zeros for every lane with out_valid[i]=0.
REQ-020 SHALL, when out_ready && count>0, pop npop = min(count, WIDTH) entries: head advances by npop; out_valid is all-or-nothing consumed.
REQ-021 SHALL update count_next = count + npush - npop when a push and a pop occur in the same cycle, with no intermediate state visible.
REQ-022 SHALL, when recover=1, set head=tail=0 and count=0 at the next edge.
- Recover has priority over a same-cycle push and pop; both are discarded.
REQ-023 SHALL, in the cycle recover is asserted, still present the pre-flush out_valid and uop_out; the consumer discards them.
REQ-024 SHALL not modify storage contents on pop or flush; only pointers and count change.
REQ-025 SHALL make out_valid and uop_out combinational from registered state only, with no path from in_valid, uop_in, or out_ready.
REQ-026 SHALL have zero-bubble latency: a uop pushed at edge N is visible on uop_out in the cycle after edge N if it is within the oldest WIDTH entries.
REQ-027 SHALL keep count within 0..DEPTH; overflow is impossible by REQ-014 and underflow by REQ-020.

Reset
REQ-028 SHALL, while reset=0, asynchronously force head=0, tail=0, count=0, hence out_valid=0, uop_out all zeros, and in_ready=1.
REQ-029 SHALL leave entry storage unreset.
REQ-030 SHALL, on reset assertion mid-operation, drop all entries immediately, with the first push permitted at the first rising edge after reset deasserts.

Verification (WIDTH=2, DEPTH=8)
REQ-031 SHALL cover: reset -> count=0, out_valid=2'b00, in_ready=1; push uops A,B with out_ready=0 -> next cycle count=2, out_valid=2'b11, uop_out={B,A}.
REQ-032 SHALL cover: push four full groups with out_ready=0 -> count=8, in_ready=0; further in_valid=2'b11 -> count remains 8, contents unchanged.
REQ-033 SHALL cover: count=7, out_ready=0 -> in_ready=0; assert out_ready -> pop 2 -> count=5, in_ready=1.
REQ-034 SHALL cover: in_valid=2'b10 carrying C on an empty queue -> next cycle out_valid=2'b01, uop_out[0]=C.
REQ-035 SHALL cover: 20 cycles of simultaneous full push and pop -> count stays constant, pointers wrap past 7, output order is strictly FIFO.
REQ-036 SHALL cover: count=6 with recover=1, in_valid=2'b11, out_ready=1 -> next cycle count=0, out_valid=0; async reset pulse mid-stream -> outputs cleared before the next edge.
